// File: rtl/xa_sector_scheduler_if.sv
// Coding-byte type shared by the CD front end and the audio player, plus the
// bundle of sector, host and player signals around xa_sector_scheduler.
package xa_sector_pkg;
  // CD-XA subheader coding byte, MSB first.
  typedef struct packed {
    logic       reserved;
    logic       emphasis;
    logic [1:0] bits_per_sample;
    logic [1:0] sample_rate;
    logic [1:0] channels;
  } header_coding_s;
endpackage

interface xa_sector_scheduler_if #(
  parameter int QUEUE_DEPTH = 4
);
  import xa_sector_pkg::*;

  localparam int LVL_W = $clog2(QUEUE_DEPTH) + 1;

  logic                 sector_valid;
  logic [12:0]          sector_addr;
  header_coding_s       sector_coding;
  logic                 audiomap_req;
  logic                 audiomap_stop;
  logic                 player_idle;
  logic                 audiomap_active;
  logic                 start_playback;
  logic [12:0]          playback_addr;
  header_coding_s       cd_audio_coding;
  logic                 enable_audiomap;
  logic                 disable_audiomap;
  logic                 sector_done;
  logic [LVL_W-1:0]     queue_level;
  logic [7:0]           drop_count;
  logic                 stall_err;

  modport master (
    input  sector_valid, sector_addr, sector_coding,
    input  audiomap_req, audiomap_stop, player_idle, audiomap_active,
    output start_playback, playback_addr, cd_audio_coding,
    output enable_audiomap, disable_audiomap, sector_done,
    output queue_level, drop_count, stall_err
  );

  modport slave (
    output sector_valid, sector_addr, sector_coding,
    output audiomap_req, audiomap_stop, player_idle, audiomap_active,
    input  start_playback, playback_addr, cd_audio_coding,
    input  enable_audiomap, disable_audiomap, sector_done,
    input  queue_level, drop_count, stall_err
  );
endinterface

// File: rtl/xa_sector_scheduler.sv
// Queues completed XA audio sectors and hands them to the player one at a time,
// serialising CD playback against host audiomap playback.
module xa_sector_scheduler
  import xa_sector_pkg::*;
#(
  parameter int QUEUE_DEPTH  = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  xa_sector_scheduler_if.master bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_IDLE,
    MAP_ENABLE,
    MAP_ACTIVE
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             map_pend_q, map_pend_d;
  logic             seen_q, seen_d;
  logic             start_q, start_d;
  logic [12:0]      addr_q, addr_d;
  header_coding_s   coding_q, coding_d;
  logic             en_q, en_d;
  logic             dis_q, dis_d;
  logic             done_q, done_d;
  logic [7:0]       drop_q, drop_d;
  logic             stall_q, stall_d;

  logic [12:0]      addr_mem   [QUEUE_DEPTH];
  header_coding_s   coding_mem [QUEUE_DEPTH];

  logic             map_mode;
  logic             full;
  logic             empty;
  logic             pop;
  logic             flush;
  logic             push;
  logic             drop_now;
  logic [LVL_W-1:0] flushed;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [9:0] b);
    logic [9:0] s;
    s = {2'b00, a} + b;
    return (s > 10'd255) ? 8'hFF : s[7:0];
  endfunction

  assign map_mode = (state_q == MAP_ENABLE) || (state_q == MAP_ACTIVE);
  assign full     = (count_q == LVL_W'(QUEUE_DEPTH));
  assign empty    = (count_q == '0);

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    seen_d     = seen_q;
    map_pend_d = map_pend_q | (bus.audiomap_req & ~map_mode);
    start_d    = 1'b0;
    addr_d     = addr_q;
    coding_d   = coding_q;
    en_d       = 1'b0;
    dis_d      = 1'b0;
    done_d     = 1'b0;
    stall_d    = stall_q;
    pop        = 1'b0;
    flush      = 1'b0;

    case (state_q)
      IDLE: begin
        if (map_pend_q) begin
          state_d    = MAP_ENABLE;
          en_d       = 1'b1;
          map_pend_d = 1'b0;
        // Holding off one cycle after sector_done spaces back-to-back issues.
        end else if (!empty && bus.player_idle && !done_q) begin
          state_d  = ISSUE;
          start_d  = 1'b1;
          addr_d   = addr_mem[rd_ptr_q];
          coding_d = coding_mem[rd_ptr_q];
        end
      end
      ISSUE: begin
        pop     = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!bus.player_idle) begin
          state_d = WAIT_IDLE;
        end else if (tmo_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
          stall_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (bus.player_idle) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      MAP_ENABLE: begin
        flush   = 1'b1;
        seen_d  = 1'b0;
        state_d = MAP_ACTIVE;
      end
      MAP_ACTIVE: begin
        dis_d = bus.audiomap_stop;
        if (bus.audiomap_active) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full queue still accepts a push when the head leaves in the same cycle.
  always_comb begin
    push     = bus.sector_valid && !map_mode && (!full || pop);
    drop_now = bus.sector_valid && !push;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    flushed  = '0;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
      flushed  = count_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + LVL_W'(push) - LVL_W'(pop);
    end
    drop_d = sat_add8(drop_q, 10'(flushed) + 10'(drop_now));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      tmo_q      <= '0;
      map_pend_q <= 1'b0;
      seen_q     <= 1'b0;
      start_q    <= 1'b0;
      addr_q     <= '0;
      coding_q   <= '0;
      en_q       <= 1'b0;
      dis_q      <= 1'b0;
      done_q     <= 1'b0;
      drop_q     <= '0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      map_pend_q <= map_pend_d;
      seen_q     <= seen_d;
      start_q    <= start_d;
      addr_q     <= addr_d;
      coding_q   <= coding_d;
      en_q       <= en_d;
      dis_q      <= dis_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      stall_q    <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q]   <= bus.sector_addr;
      coding_mem[wr_ptr_q] <= bus.sector_coding;
    end
  end

  assign bus.start_playback   = start_q;
  assign bus.playback_addr    = addr_q;
  assign bus.cd_audio_coding  = coding_q;
  assign bus.enable_audiomap  = en_q;
  assign bus.disable_audiomap = dis_q;
  assign bus.sector_done      = done_q;
  assign bus.queue_level      = count_q;
  assign bus.drop_count       = drop_q;
  assign bus.stall_err        = stall_q;

endmodule

// File: tb/tb_xa_sector_scheduler.sv
// Directed bench for xa_sector_scheduler: scoreboarded issue order, drop
// accounting, timeout, audiomap preemption/stop and reset behaviour.
module tb_xa_sector_scheduler;
  import xa_sector_pkg::*;

  localparam int QD  = 4;
  localparam int TMO = 16;

  typedef struct packed {
    logic [12:0]    addr;
    header_coding_s coding;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  xa_sector_scheduler_if #(.QUEUE_DEPTH(QD)) bus ();

  xa_sector_scheduler #(.QUEUE_DEPTH(QD), .BUSY_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int  pass_cnt = 0;
  int  fail_cnt = 0;
  int  total    = 0;
  int  exp_drop = 0;
  sb_t sb_q[$];

  int done_seen  = 0;
  int en_seen    = 0;
  int start_seen = 0;
  always @(posedge clk) begin
    if (bus.sector_done === 1'b1)     done_seen  <= done_seen + 1;
    if (bus.enable_audiomap === 1'b1) en_seen    <= en_seen + 1;
    if (bus.start_playback === 1'b1)  start_seen <= start_seen + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic push_sector(input logic [12:0] a, input header_coding_s c, input bit accept);
    sb_t e;
    bus.sector_valid  = 1'b1;
    bus.sector_addr   = a;
    bus.sector_coding = c;
    tick();
    bus.sector_valid  = 1'b0;
    e.addr   = a;
    e.coding = c;
    if (accept) sb_q.push_back(e);
    else exp_drop = sat(exp_drop + 1);
  endtask

  task automatic compare_issue(input string tag);
    sb_t e;
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_addr"}, 32'(bus.playback_addr), 32'(e.addr));
      check({tag, "_coding"}, 32'(bus.cd_audio_coding), 32'(e.coding));
    end
  endtask

  task automatic wait_start(input string tag, input int max);
    int n = 0;
    while (bus.start_playback !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check({tag, "_start"}, 32'(bus.start_playback), 32'd1);
    if (bus.start_playback === 1'b1) compare_issue(tag);
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (bus.sector_done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(bus.sector_done), 32'd1);
  endtask

  // Player model: goes busy two cycles after the start, idle again three later.
  task automatic serve(input string tag);
    tick();
    tick();
    bus.player_idle = 1'b0;
    repeat (3) tick();
    bus.player_idle = 1'b1;
    wait_done(tag, 20);
    tick();
    check({tag, "_gap"}, 32'(bus.start_playback), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 32'(bus.start_playback), 32'd0);
    check({tag, "_addr"}, 32'(bus.playback_addr), 32'd0);
    check({tag, "_coding"}, 32'(bus.cd_audio_coding), 32'd0);
    check({tag, "_en"}, 32'(bus.enable_audiomap), 32'd0);
    check({tag, "_dis"}, 32'(bus.disable_audiomap), 32'd0);
    check({tag, "_done"}, 32'(bus.sector_done), 32'd0);
    check({tag, "_level"}, 32'(bus.queue_level), 32'd0);
    check({tag, "_drop"}, 32'(bus.drop_count), 32'd0);
    check({tag, "_stall"}, 32'(bus.stall_err), 32'd0);
  endtask

  initial begin
    header_coding_s c37s;
    header_coding_s c18m;
    int done_base;
    int en_base;
    int start_base;

    c37s = 8'h01;
    c18m = 8'h14;

    reset               = 1'b1;
    bus.sector_valid    = 1'b0;
    bus.sector_addr     = '0;
    bus.sector_coding   = '0;
    bus.audiomap_req    = 1'b0;
    bus.audiomap_stop   = 1'b0;
    bus.player_idle     = 1'b1;
    bus.audiomap_active = 1'b0;
    repeat (3) tick();
    check_all_zero("rst");
    reset = 1'b0;
    tick();

    // Single sector: N+1 level 1, N+2 start, N+3 level 0.
    done_base = done_seen;
    push_sector(13'h0A00, c37s, 1'b1);
    check("single_level_n1", 32'(bus.queue_level), 32'd1);
    check("single_start_n1", 32'(bus.start_playback), 32'd0);
    tick();
    check("single_start_n2", 32'(bus.start_playback), 32'd1);
    compare_issue("single");
    tick();
    check("single_level_n3", 32'(bus.queue_level), 32'd0);
    check("single_start_n3", 32'(bus.start_playback), 32'd0);
    check("single_addr_hold", 32'(bus.playback_addr), 32'h0A00);
    tick();
    tick();
    bus.player_idle = 1'b0;
    repeat (100) tick();
    check("single_no_early_done", 32'(done_seen - done_base), 32'd0);
    bus.player_idle = 1'b1;
    wait_done("single", 10);
    repeat (4) tick();
    check("single_done_count", 32'(done_seen - done_base), 32'd1);

    // Overflow: six pushes into a four-entry queue while the player is busy.
    bus.player_idle = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) push_sector(13'(13'h0100 + i), 8'(i), i < QD);
    check("ovf_level", 32'(bus.queue_level), 32'd4);
    check("ovf_drop", 32'(bus.drop_count), 32'(exp_drop));
    bus.player_idle = 1'b1;
    for (int i = 0; i < QD; i++) begin
      wait_start($sformatf("ovf%0d", i), 10);
      serve($sformatf("ovf%0d", i));
    end
    check("ovf_sb_drained", 32'(sb_q.size()), 32'd0);

    // Busy timeout: player never leaves idle.
    push_sector(13'h1234, c18m, 1'b1);
    wait_start("tmo", 5);
    done_base = done_seen;
    repeat (TMO) tick();
    check("tmo_stall_before", 32'(bus.stall_err), 32'd0);
    tick();
    check("tmo_stall_set", 32'(bus.stall_err), 32'd1);
    repeat (3) tick();
    check("tmo_no_done", 32'(done_seen - done_base), 32'd0);
    check("tmo_stall_sticky", 32'(bus.stall_err), 32'd1);

    // Audiomap preemption flushes three queued sectors.
    bus.player_idle = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) push_sector(13'(13'h0200 + i), c37s, 1'b1);
    check("map_level3", 32'(bus.queue_level), 32'd3);
    en_base = en_seen;
    bus.audiomap_req = 1'b1;
    tick();
    bus.audiomap_req = 1'b0;
    check("map_en_n1", 32'(bus.enable_audiomap), 32'd0);
    tick();
    check("map_en_n2", 32'(bus.enable_audiomap), 32'd1);
    tick();
    exp_drop = sat(exp_drop + 3);
    sb_q.delete();
    check("map_flush_level", 32'(bus.queue_level), 32'd0);
    check("map_flush_drop", 32'(bus.drop_count), 32'(exp_drop));
    push_sector(13'h0777, c37s, 1'b0);
    check("map_active_drop", 32'(bus.drop_count), 32'(exp_drop));
    bus.audiomap_req = 1'b1;
    tick();
    bus.audiomap_req = 1'b0;
    bus.audiomap_active = 1'b1;
    tick();
    bus.audiomap_active = 1'b0;
    tick();
    repeat (4) tick();
    check("map_req_ignored", 32'(en_seen - en_base), 32'd1);
    bus.player_idle = 1'b1;
    push_sector(13'h0321, c18m, 1'b1);
    wait_start("map_after", 6);
    serve("map_after");

    // Host stop with a coincident request: stop wins.
    en_base = en_seen;
    bus.player_idle = 1'b0;
    bus.audiomap_req = 1'b1;
    tick();
    bus.audiomap_req = 1'b0;
    tick();
    tick();
    bus.audiomap_active = 1'b1;
    tick();
    bus.audiomap_stop = 1'b1;
    bus.audiomap_req  = 1'b1;
    tick();
    bus.audiomap_stop = 1'b0;
    bus.audiomap_req  = 1'b0;
    check("stop_dis_pulse", 32'(bus.disable_audiomap), 32'd1);
    tick();
    check("stop_dis_clear", 32'(bus.disable_audiomap), 32'd0);
    bus.audiomap_active = 1'b0;
    repeat (5) tick();
    check("stop_single_enable", 32'(en_seen - en_base), 32'd1);
    check("stop_drop_same", 32'(bus.drop_count), 32'(exp_drop));
    bus.player_idle = 1'b1;
    push_sector(13'h0456, c37s, 1'b1);
    wait_start("stop_after", 6);
    serve("stop_after");

    // Saturation, then reset while waiting for the decoder to finish.
    bus.player_idle = 1'b0;
    tick();
    for (int i = 0; i < 304; i++) push_sector(13'(i), c18m, i < QD);
    check("sat_level", 32'(bus.queue_level), 32'd4);
    check("sat_drop", 32'(bus.drop_count), 32'(exp_drop));
    bus.player_idle = 1'b1;
    wait_start("sat", 6);
    tick();
    tick();
    bus.player_idle = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    bus.player_idle = 1'b1;
    tick();
    check_all_zero("midrst");
    reset = 1'b0;
    sb_q.delete();
    done_base  = done_seen;
    start_base = start_seen;
    repeat (6) tick();
    check("midrst_no_done", 32'(done_seen - done_base), 32'd0);
    check("midrst_no_start", 32'(start_seen - start_base), 32'd0);
    check("midrst_level", 32'(bus.queue_level), 32'd0);
    check("midrst_drop", 32'(bus.drop_count), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
